// File: rtl/i2s_sync_receiver.sv
// I2S receiver for the system clock domain. The raw sck/ws/sd pins are
// synchronised and oversampled. Each channel slot is checked for the expected
// length. Complete stereo pairs are presented with a one-cycle valid pulse.
module i2s_sync_receiver #(
  parameter int SLOT_BITS   = 32,
  parameter int WORDSIZE    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                ws,
  input  logic                sd,
  output logic [WORDSIZE-1:0] data_left,
  output logic [WORDSIZE-1:0] data_right,
  output logic                valid,
  output logic                locked,
  output logic                frame_err
);

  localparam int SYNC_W = 3 * SYNC_STAGES;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam logic [WORDSIZE-1:0] MSB_ONE = WORDSIZE'(1) << (WORDSIZE - 1);

  typedef enum logic [1:0] {SEARCH, LEFT, RIGHT} state_t;

  state_t              state, state_nxt;
  logic [SYNC_W-1:0]   sync_q;
  logic                sck_s, ws_s, sd_s;
  logic                sck_prev, ws_prev;
  logic                rise, boundary, slot_ok, timeout_hit;
  logic [7:0]          bcnt, bcnt_inc;
  logic [TW-1:0]       tcnt;
  logic [WORDSIZE-1:0] shifter, shift_ins, hold_left;
  logic                clr_slot, ld_hold, ld_pair, err;

  // The oldest synchroniser group sits at the top of sync_q.
  // The pin order in each group is {sck, ws, sd}.
  assign sck_s = sync_q[SYNC_W-1];
  assign ws_s  = sync_q[SYNC_W-2];
  assign sd_s  = sync_q[SYNC_W-3];

  assign rise        = sck_s & ~sck_prev;
  assign boundary    = rise & (ws_s ^ ws_prev);
  assign bcnt_inc    = (bcnt == 8'hFF) ? bcnt : bcnt + 8'd1;
  assign slot_ok     = (bcnt_inc == 8'(SLOT_BITS));
  assign timeout_hit = ~rise & (tcnt == TW'(TIMEOUT - 1));

  // Bit index bcnt lands at position WORDSIZE-1-bcnt.
  // The shifted mask becomes zero once bcnt reaches WORDSIZE, so late bits drop out.
  assign shift_ins = shifter | ({WORDSIZE{sd_s}} & (MSB_ONE >> bcnt));

  // Synchronise the three I2S pins and keep the history used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      sck_prev <= 1'b0;
      ws_prev  <= 1'b0;
    end else begin
      sync_q   <= SYNC_W'({sync_q, sck, ws, sd});
      sck_prev <= sck_s;
      if (rise) ws_prev <= ws_s;
    end
  end

  // Frame-state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_nxt;
  end

  // Next-state logic and datapath strobes.
  // A mis-sized slot that ends on ws 1->0 relocks at once into LEFT.
  always_comb begin
    state_nxt = state;
    clr_slot  = 1'b0;
    ld_hold   = 1'b0;
    ld_pair   = 1'b0;
    err       = 1'b0;
    if (boundary) begin
      unique case (state)
        SEARCH: begin
          if (!ws_s) begin
            state_nxt = LEFT;
            clr_slot  = 1'b1;
          end
        end
        LEFT, RIGHT: begin
          if (slot_ok) begin
            clr_slot  = 1'b1;
            ld_hold   = (state == LEFT);
            ld_pair   = (state == RIGHT);
            state_nxt = (state == LEFT) ? RIGHT : LEFT;
          end else begin
            err = 1'b1;
            if (!ws_s) begin
              state_nxt = LEFT;
              clr_slot  = 1'b1;
            end else begin
              state_nxt = SEARCH;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end else if (timeout_hit && state != SEARCH) begin
      err       = 1'b1;
      state_nxt = SEARCH;
    end
  end

  // Slot bit counter, which saturates at 255.
  // Idle timeout counter, which restarts on every sck rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
      tcnt <= '0;
    end else begin
      if (clr_slot)  bcnt <= '0;
      else if (rise) bcnt <= bcnt_inc;
      if (rise)                        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT))   tcnt <= tcnt + TW'(1);
    end
  end

  // Sample shifter, left holding register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shifter    <= '0;
      hold_left  <= '0;
      data_left  <= '0;
      data_right <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (clr_slot)                    shifter <= '0;
      else if (rise && state != SEARCH) shifter <= shift_ins;
      if (ld_hold) hold_left <= shift_ins;
      if (ld_pair) begin
        data_left  <= hold_left;
        data_right <= shift_ins;
      end
      valid     <= ld_pair;
      frame_err <= err;
      if (err)          locked <= 1'b0;
      else if (ld_pair) locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_sync_receiver.sv
// Directed and random I2S streams for i2s_sync_receiver.
// A slot-level model predicts the pairs, the errors and the lock status.
module tb_i2s_sync_receiver;

  localparam int SLOT = 32;

  logic        clk = 1'b0;
  logic        rst, sck, ws, sd;
  logic [31:0] data_left, data_right;
  logic        valid, locked, frame_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_l[$], got_r[$], exp_l[$], exp_r[$];
  int          err_seen = 0, exp_err = 0, hold_viol = 0;
  time         t_err = 0, t_rise = 0;
  logic [31:0] pl = '0, pr = '0;

  // Slot-level model state.
  bit          aligned, left_ok, exp_locked;
  logic [31:0] pend_l, last_l, last_r;

  i2s_sync_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .data_left  (data_left),
    .data_right (data_right),
    .valid      (valid),
    .locked     (locked),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Collect presented pairs, error pulses and changes to the held data.
  always @(negedge clk) begin
    if (valid) begin
      got_l.push_back(data_left);
      got_r.push_back(data_right);
    end
    if (frame_err) begin
      err_seen++;
      t_err = $time;
    end
    if (!rst && !valid && (data_left !== pl || data_right !== pr)) hold_viol++;
    pl = data_left;
    pr = data_right;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One sck period at 16 clk per sck. ws and sd change while sck is low.
  task automatic send_bit(input logic w, input logic b);
    ws  = w;
    sd  = b;
    #80;
    sck = 1'b1;
    t_rise = $time;
    #80;
    sck = 1'b0;
  endtask

  // Send one slot MSB first. Its last bit carries the next channel's ws.
  // Then update the model from the slot length alone.
  task automatic send_slot(input logic w, input logic [31:0] v, input int len);
    for (int i = len - 1; i >= 0; i--)
      send_bit((i == 0) ? ~w : w, (i < 32) ? v[i] : 1'b0);
    if (!w) begin
      if (aligned) begin
        if (len == SLOT) begin
          pend_l  = v;
          left_ok = 1'b1;
        end else begin
          exp_err++;
          exp_locked = 1'b0;
          aligned    = 1'b0;
          left_ok    = 1'b0;
        end
      end
    end else begin
      if (aligned && left_ok) begin
        if (len == SLOT) begin
          exp_l.push_back(pend_l);
          exp_r.push_back(v);
          last_l     = pend_l;
          last_r     = v;
          exp_locked = 1'b1;
        end else begin
          exp_err++;
          exp_locked = 1'b0;
        end
      end
      aligned = 1'b1;
      left_ok = 1'b0;
    end
    check("locked_after_slot", 64'(locked), 64'(exp_locked));
  endtask

  task automatic send_pair_rand();
    send_slot(1'b0, $urandom, SLOT);
    send_slot(1'b1, $urandom, SLOT);
  endtask

  task automatic end_scenario(input string name);
    int n;
    check({name, "_pair_count"}, 64'(got_l.size()), 64'(exp_l.size()));
    n = (got_l.size() < exp_l.size()) ? got_l.size() : exp_l.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_left%0d", name, i), 64'(got_l[i]), 64'(exp_l[i]));
      check($sformatf("%s_right%0d", name, i), 64'(got_r[i]), 64'(exp_r[i]));
    end
    check({name, "_frame_err_count"}, 64'(err_seen), 64'(exp_err));
    check({name, "_held_left"}, 64'(data_left), 64'(last_l));
    check({name, "_held_right"}, 64'(data_right), 64'(last_r));
    check({name, "_hold_violations"}, 64'(hold_viol), 64'd0);
    got_l.delete(); got_r.delete(); exp_l.delete(); exp_r.delete();
    err_seen = 0;
    exp_err  = 0;
  endtask

  task automatic reset_model();
    aligned    = 1'b0;
    left_ok    = 1'b0;
    exp_locked = 1'b0;
    last_l     = '0;
    last_r     = '0;
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check({name, "_rst_left"}, 64'(data_left), 64'd0);
    check({name, "_rst_right"}, 64'(data_right), 64'd0);
    check({name, "_rst_valid"}, 64'(valid), 64'd0);
    check({name, "_rst_locked"}, 64'(locked), 64'd0);
    check({name, "_rst_frame_err"}, 64'(frame_err), 64'd0);
    rst = 1'b0;
    reset_model();
    @(negedge clk);
  endtask

  initial begin
    int err_before, d;
    sck = 1'b0; ws = 1'b0; sd = 1'b0; rst = 1'b1;
    reset_model();
    @(negedge clk);
    pulse_reset("por");

    // Scenario 1: lock onto a standard 32-bit stream.
    send_slot(1'b1, $urandom, 4);
    send_slot(1'b0, 32'hA5A5_0001, SLOT);
    send_slot(1'b1, 32'h0000_FFFE, SLOT);
    check("s1_first_left", 64'(data_left), 64'hA5A5_0001);
    check("s1_first_right", 64'(data_right), 64'h0000_FFFE);
    check("s1_locked", 64'(locked), 64'd1);
    repeat (3) send_pair_rand();
    end_scenario("s1");

    // Scenario 2: a 24-bit sample followed by zero padding in a 32-bit slot.
    send_slot(1'b0, 32'h1234_5600, SLOT);
    send_slot(1'b1, $urandom, SLOT);
    check("s2_left24", 64'(data_left), 64'h1234_5600);
    end_scenario("s2");

    // Scenario 3: a short right slot, then a long left slot.
    send_slot(1'b0, $urandom, SLOT);
    send_slot(1'b1, $urandom, 31);
    check("s3_locked_after_short", 64'(locked), 64'd0);
    send_pair_rand();
    send_pair_rand();
    send_slot(1'b0, $urandom, 33);
    send_slot(1'b1, $urandom, SLOT);
    send_pair_rand();
    end_scenario("s3");

    // Scenario 4: sck stops in the middle of a left slot.
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom));
    err_before = err_seen;
    repeat (300) @(negedge clk);
    check("s4_timeout_pulses", 64'(err_seen - err_before), 64'd1);
    check("s4_locked", 64'(locked), 64'd0);
    d = int'((t_err - t_rise) / 10);
    check("s4_timeout_delay_in_255_260", 64'(d >= 255 && d <= 260), 64'd1);
    exp_err++;
    aligned    = 1'b0;
    left_ok    = 1'b0;
    exp_locked = 1'b0;
    send_slot(1'b1, $urandom, 3);
    send_pair_rand();
    send_pair_rand();
    end_scenario("s4");

    // Scenario 5: reset in the middle of a left slot.
    send_pair_rand();
    end_scenario("s5a");
    for (int i = 0; i < 12; i++) send_bit(1'b0, 1'($urandom));
    pulse_reset("s5");
    send_slot(1'b0, $urandom, 20);
    send_slot(1'b1, $urandom, SLOT);
    check("s5_no_pair_yet", 64'(got_l.size()), 64'd0);
    send_pair_rand();
    end_scenario("s5");

    // Scenario 6: the stream starts in the middle of a right slot.
    pulse_reset("s6");
    send_slot(1'b1, $urandom, 13);
    check("s6_quiet_before_lock", 64'(got_l.size() + err_seen), 64'd0);
    send_pair_rand();
    send_pair_rand();
    end_scenario("s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
